// File: rtl/obi_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// obi_rr_arbiter_if
//   Bundles the bus-side signals of obi_rr_arbiter: the NB_MASTER OBI
//   request/grant master ports (packed per master), the shared slave port,
//   and the two status flags. Signal names keep the arbiter-relative _i/_o
//   suffixes so they read the same inside and outside the arbiter.
//
//   modport slave  : the arbiter's view (it is the slave of the masters' bus
//                    and drives the shared slave port)
//   modport master : the environment's view (masters plus the shared slave
//                    device)
//
//   m_req_i    [NB]          per-master request
//   m_addr_i   [NB*AW]       per-master address, master i at [i*AW +: AW]
//   m_we_i     [NB]          per-master write enable
//   m_be_i     [NB*DW/8]     per-master byte enables
//   m_wdata_i  [NB*DW]       per-master write data
//   m_gnt_o    [NB]          per-master grant, one-hot or zero
//   m_rvalid_o [NB]          per-master response valid, one-hot or zero
//   m_rdata_o  [DW]          response data, broadcast
//   s_req_o / s_addr_o / s_we_o / s_be_o / s_wdata_o   slave request side
//   s_gnt_i / s_rvalid_i / s_rdata_i                   slave response side
//   busy_o                   any transaction outstanding
//   err_o                    sticky: response arrived with nothing outstanding
// -----------------------------------------------------------------------------
interface obi_rr_arbiter_if #(
  parameter int unsigned NB_MASTER  = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NB_MASTER-1:0]              m_req_i;
  logic [NB_MASTER*ADDR_WIDTH-1:0]   m_addr_i;
  logic [NB_MASTER-1:0]              m_we_i;
  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i;
  logic [NB_MASTER*DATA_WIDTH-1:0]   m_wdata_i;
  logic [NB_MASTER-1:0]              m_gnt_o;
  logic [NB_MASTER-1:0]              m_rvalid_o;
  logic [DATA_WIDTH-1:0]             m_rdata_o;

  logic                              s_req_o;
  logic [ADDR_WIDTH-1:0]             s_addr_o;
  logic                              s_we_o;
  logic [DATA_WIDTH/8-1:0]           s_be_o;
  logic [DATA_WIDTH-1:0]             s_wdata_o;
  logic                              s_gnt_i;
  logic                              s_rvalid_i;
  logic [DATA_WIDTH-1:0]             s_rdata_i;

  logic                              busy_o;
  logic                              err_o;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output busy_o, err_o
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  busy_o, err_o
  );
endinterface

// File: rtl/obi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// obi_rr_arbiter
//   Shares one single-port OBI slave (data RAM wrapper) among NB_MASTER
//   request/grant masters (core data port, debug unit, SPI-slave loader).
//   Round-robin arbitration; once a request is presented to the slave it is
//   locked until granted so the slave sees a stable request. An in-order ID
//   FIFO of depth MAX_OUTSTANDING routes each response to its issuer.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    obi_rr_arbiter_if.slave (masters, shared slave port, status)
// -----------------------------------------------------------------------------
module obi_rr_arbiter #(
  parameter int unsigned NB_MASTER       = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  obi_rr_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NB_MASTER);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam idx_t LAST_IDX = idx_t'(NB_MASTER - 1);
  localparam ptr_t LAST_PTR = ptr_t'(MAX_OUTSTANDING - 1);
  localparam cnt_t MAX_CNT  = cnt_t'(MAX_OUTSTANDING);

  // First requester at or after ptr, wrapping modulo NB_MASTER.
  function automatic idx_t rr_pick(input logic [NB_MASTER-1:0] req, input idx_t ptr);
    idx_t        pick  = ptr;
    logic        found = 1'b0;
    logic [31:0] cand;
    for (int k = 0; k < NB_MASTER; k++) begin
      cand = (32'(ptr) + 32'(k)) % NB_MASTER;
      if (!found && req[cand]) begin
        pick  = idx_t'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  idx_t rr_ptr_q,     rr_ptr_d;
  logic lock_q,       lock_d;
  idx_t locked_idx_q, locked_idx_d;
  ptr_t head_q,       head_d;
  ptr_t tail_q,       tail_d;
  cnt_t count_q,      count_d;
  logic err_q,        err_d;

  idx_t fifo_mem [MAX_OUTSTANDING];

  // ---------------------------------------------------------------------------
  // Arbitration and issue
  // ---------------------------------------------------------------------------
  idx_t sel;
  logic any_req;
  logic fifo_full;
  logic issue;
  logic push;
  logic pop;

  assign any_req   = |bus.m_req_i;
  assign fifo_full = (count_q == MAX_CNT);
  assign sel       = lock_q ? locked_idx_q : rr_pick(bus.m_req_i, rr_ptr_q);

  // Outputs are forced low while rst_n is asserted, not just the state, so
  // that a requesting master cannot reach the slave during reset. No bypass
  // when full: a same-cycle pop does not free a slot for this cycle's issue.
  assign issue = rst_n && (any_req || lock_q) && !fifo_full;
  assign push  = issue && bus.s_gnt_i;
  assign pop   = bus.s_rvalid_i && (count_q != '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first so no path leaves
  // it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    err_d        = err_q;

    if (push) begin
      rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + idx_t'(1);
      lock_d   = 1'b0;
      tail_d   = (tail_q == LAST_PTR) ? '0 : tail_q + ptr_t'(1);
    end else if (issue) begin
      // Presented but not granted: hold this master until the slave accepts.
      lock_d       = 1'b1;
      locked_idx_d = sel;
    end

    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + ptr_t'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    // Response with nothing outstanding: flag it, change nothing else.
    if (bus.s_rvalid_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the ID storage is deliberately not reset; an entry is only read
  // between its push and pop, and count/pointers (which are reset) guard that.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_q] <= sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.m_gnt_o    = '0;
    bus.m_rvalid_o = '0;
    if (push) begin
      bus.m_gnt_o[sel] = 1'b1;
    end
    if (pop) begin
      bus.m_rvalid_o[fifo_mem[head_q]] = 1'b1;
    end
  end

  assign bus.m_rdata_o = bus.s_rdata_i;

  assign bus.s_req_o   = issue;
  assign bus.s_addr_o  = rst_n ? bus.m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.s_we_o    = rst_n ? bus.m_we_i[sel]                            : 1'b0;
  assign bus.s_be_o    = rst_n ? bus.m_be_i[sel*BE_W +: BE_W]               : '0;
  assign bus.s_wdata_o = rst_n ? bus.m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign bus.busy_o    = (count_q != '0);
  assign bus.err_o     = err_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.m_gnt_o));
  a_rvalid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.m_rvalid_o));
  a_no_gnt_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full |-> (bus.m_gnt_o == '0));

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obi_rr_arbiter
//   Self-checking bench for obi_rr_arbiter (NB_MASTER=3, MAX_OUTSTANDING=2).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge. A behavioural slave answers every handshake in order
//   after a configurable latency with data derived from the address. Each
//   expected grant pushes the expected master ID and response data onto a
//   scoreboard queue; each response popped from the DUT is compared with it.
// -----------------------------------------------------------------------------
module tb_obi_rr_arbiter;

  localparam int NB  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MO  = 2;
  localparam logic [31:0] KEY = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  obi_rr_arbiter_if #(.NB_MASTER(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  obi_rr_arbiter #(
    .NB_MASTER(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          lat    = 1;
  int          seq [NB];
  rsp_t        rsp_q [$];
  int          exp_id_q [$];
  logic [31:0] exp_data_q [$];

  // ---------------------------------------------------------------------------
  // Master payload model: each master walks through a sequence of requests.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 | (32'(i) << 8) | (32'(seq[i]) << 2);
  endfunction
  function automatic logic we_of(input int i);
    return seq[i][0];
  endfunction
  function automatic logic [3:0] be_of(input int i);
    return 4'hF >> i;
  endfunction
  function automatic logic [31:0] wdata_of(input int i);
    return {16'hC0DE, 8'(i), 8'(seq[i])};
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < NB; i++) begin
      bus.m_addr_i[i*AW +: AW]   = addr_of(i);
      bus.m_we_i[i]              = we_of(i);
      bus.m_be_i[i*4 +: 4]       = be_of(i);
      bus.m_wdata_i[i*DW +: DW]  = wdata_of(i);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One clock cycle. exp_* = -1 means "not checked this cycle".
  // ---------------------------------------------------------------------------
  task automatic tick(input logic [NB-1:0] req_v, input bit gnt_v, input int exp_gnt,
                      input int exp_sel, input int exp_sreq, input int exp_busy,
                      input bit spur);
    logic [NB-1:0] exp_vec;
    logic [NB-1:0] exp_rv;
    logic [31:0]   exp_d;
    bit            real_rv;
    bit            rv;

    real_rv = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    rv      = real_rv || spur;
    bus.m_req_i    = req_v;
    drive_payload();
    bus.s_gnt_i    = gnt_v;
    bus.s_rvalid_i = rv;
    bus.s_rdata_i  = real_rv ? rsp_q[0].data : (32'hBAD0_0000 ^ 32'(cyc));

    @(negedge clk);

    exp_vec = '0;
    if (exp_gnt >= 0) exp_vec[exp_gnt] = 1'b1;
    checks++;
    if (bus.m_gnt_o !== exp_vec) begin
      errors++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, bus.m_gnt_o, exp_vec);
    end

    if (exp_sel >= 0) begin
      checks++;
      if ({bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o} !==
          {addr_of(exp_sel), we_of(exp_sel), be_of(exp_sel), wdata_of(exp_sel)}) begin
        errors++;
        $display("FAIL slave_mux cyc=%0d got addr=%h we=%b be=%h wd=%h exp master %0d addr=%h",
                 cyc, bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o, exp_sel, addr_of(exp_sel));
      end
    end

    if (exp_sreq >= 0) begin
      checks++;
      if (bus.s_req_o !== 1'(exp_sreq)) begin
        errors++;
        $display("FAIL s_req cyc=%0d got=%b exp=%0d", cyc, bus.s_req_o, exp_sreq);
      end
    end

    if (exp_busy >= 0) begin
      checks++;
      if (bus.busy_o !== 1'(exp_busy)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%0d", cyc, bus.busy_o, exp_busy);
      end
    end

    // Scoreboard pop: a response is owed only if a grant was expected earlier.
    exp_rv = '0;
    exp_d  = '0;
    if (rv && exp_id_q.size() > 0) begin
      exp_rv[exp_id_q.pop_front()] = 1'b1;
      exp_d = exp_data_q.pop_front();
    end
    checks++;
    if (bus.m_rvalid_o !== exp_rv) begin
      errors++;
      $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, bus.m_rvalid_o, exp_rv);
    end
    if (exp_rv != '0) begin
      checks++;
      if (bus.m_rdata_o !== exp_d) begin
        errors++;
        $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, bus.m_rdata_o, exp_d);
      end
    end

    // Behavioural slave: accept on handshake, answer in order after lat.
    if (bus.s_req_o && gnt_v) rsp_q.push_back('{due: cyc + lat, data: bus.s_addr_o ^ KEY});
    if (real_rv) void'(rsp_q.pop_front());

    // Scoreboard push for the expected grant; the master moves to its next request.
    if (exp_gnt >= 0) begin
      exp_id_q.push_back(exp_gnt);
      exp_data_q.push_back(addr_of(exp_gnt) ^ KEY);
      seq[exp_gnt]++;
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (rsp_q.size() > 0 && n < 40) begin
      tick('0, 1'b0, -1, -1, 0, -1, 1'b0);
      n++;
    end
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", rsp_q.size());
    end
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got=%0d outstanding exp=0", exp_id_q.size());
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_drain got=%b exp=0", bus.busy_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n          = 1'b0;
    bus.m_req_i    = '1;
    drive_payload();
    bus.s_gnt_i    = 1'b1;
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.s_req_o, bus.m_gnt_o, bus.m_rvalid_o, bus.busy_o, bus.err_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b gnt=%b rv=%b busy=%b err=%b exp all 0",
               bus.s_req_o, bus.m_gnt_o, bus.m_rvalid_o, bus.busy_o, bus.err_o);
    end
    checks++;
    if ({bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_payload got addr=%h be=%h wd=%h exp 0", bus.s_addr_o, bus.s_be_o, bus.s_wdata_o);
    end
    checks++;
    if (bus.m_rdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=deadbeef", bus.m_rdata_o);
    end
    bus.s_rvalid_i = 1'b0;
    bus.m_req_i    = '0;
    rst_n          = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    checks++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got err=%b busy=%b exp 0 0", bus.err_o, bus.busy_o);
    end
  endtask

  // All masters request; slave grants every cycle, answers 1 cycle later.
  task automatic test_round_robin();
    lat = 1;
    for (int k = 0; k < 6; k++) tick(3'b111, 1'b1, k % 3, k % 3, 1, (k == 0) ? 0 : 1, 1'b0);
    drain();
  endtask

  // Master 2 presented but not granted; master 0 arrives; lock holds master 2.
  task automatic test_lock();
    lat = 1;
    tick(3'b100, 1'b0, -1, 2, 1, -1, 1'b0);
    tick(3'b101, 1'b0, -1, 2, 1, -1, 1'b0);
    tick(3'b101, 1'b0, -1, 2, 1, -1, 1'b0);
    tick(3'b101, 1'b1,  2, 2, 1, -1, 1'b0);
    tick(3'b001, 1'b1,  0, 0, 1, -1, 1'b0);
    drain();
  endtask

  // Responses delayed 5 cycles: FIFO fills after two grants, no bypass on pop.
  task automatic test_fifo_full();
    lat = 5;
    tick(3'b111, 1'b1, 1, 1, 1, 0, 1'b0);
    tick(3'b111, 1'b1, 2, 2, 1, 1, 1'b0);
    for (int k = 2; k <= 5; k++) tick(3'b111, 1'b1, -1, -1, 0, 1, 1'b0);
    tick(3'b111, 1'b1, 0, 0, 1, 1, 1'b0);
    tick(3'b111, 1'b1, 1, 1, 1, 1, 1'b0);
    drain();
  endtask

  // Grant and response in the same cycle with one outstanding.
  task automatic test_back_to_back();
    lat = 1;
    tick(3'b001, 1'b1,  0,  0, 1, 0, 1'b0);
    tick(3'b010, 1'b1,  1,  1, 1, 1, 1'b0);
    tick(3'b000, 1'b0, -1, -1, 0, 1, 1'b0);
    drain();
  endtask

  task automatic test_spurious();
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_before_spurious got=%b exp=0", bus.err_o);
    end
    tick('0, 1'b0, -1, -1, 0, 0, 1'b1);
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_set got=%b exp=1", bus.err_o);
    end
    for (int k = 0; k < 3; k++) tick('0, 1'b0, -1, -1, 0, 0, 1'b0);
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=1", bus.err_o);
    end
  endtask

  // Reset with two transactions in flight; their late responses are spurious.
  task automatic test_reset_mid();
    lat = 10;
    tick(3'b111, 1'b1, 2, 2, 1, -1, 1'b0);
    tick(3'b111, 1'b1, 0, 0, 1,  1, 1'b0);
    rst_n          = 1'b0;
    bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i  = 32'h1234_5678;
    #1;
    checks++;
    if ({bus.busy_o, bus.s_req_o, bus.m_gnt_o, bus.err_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b req=%b gnt=%b err=%b exp all 0",
               bus.busy_o, bus.s_req_o, bus.m_gnt_o, bus.err_o);
    end
    checks++;
    if (bus.m_rdata_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL mid_reset_rdata got=%h exp=12345678", bus.m_rdata_o);
    end
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
    exp_id_q.delete();
    exp_data_q.delete();
    drain();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL stale_rsp_err got=%b exp=1", bus.err_o);
    end
    // rr_ptr back at 0 and no lock: master 0 wins over master 2.
    lat = 1;
    tick(3'b101, 1'b1, 0, 0, 1, 0, 1'b0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < NB; i++) seq[i] = 0;
    test_reset();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
